// File: rtl/frodo_pkg.sv
// FrodoKEM sequencer shared definitions.
// Opcodes, instruction fields, latencies and program bases.
package frodo_pkg;

  localparam int INST_W = 28;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 6;
  localparam int PC_W   = 4;
  localparam int CNT_W  = 8;

  localparam int OP_LSB   = 25;
  localparam int ADDR_LSB = 13;
  localparam int LEN_LSB  = 7;
  localparam int PORT_LSB = 5;
  localparam int A_LSB    = 21;
  localparam int B_LSB    = 17;
  localparam int C_LSB    = 13;
  localparam int MODE_LSB = 11;

  typedef enum logic [2:0] {
    OP_LOAD     = 3'b000,
    OP_STORE    = 3'b001,
    OP_RSVD     = 3'b010,
    OP_SAMPLE   = 3'b011,
    OP_MATMUL   = 3'b100,
    OP_MATMUL_T = 3'b101,
    OP_CODEC    = 3'b110,
    OP_END      = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_FINISH
  } state_e;

  localparam logic [CNT_W-1:0] LAT_SAMPLE  = 8'd24;
  localparam logic [CNT_W-1:0] LAT_CODEC   = 8'd16;
  localparam logic [CNT_W-1:0] LAT_MM_640  = 8'd80;
  localparam logic [CNT_W-1:0] LAT_MM_976  = 8'd122;
  localparam logic [CNT_W-1:0] LAT_MM_1344 = 8'd168;
  localparam logic [CNT_W-1:0] LAT_XFER_0  = 8'd64;

  localparam logic [PC_W-1:0] BASE_KEYGEN = 4'd0;
  localparam logic [PC_W-1:0] BASE_ENCAPS = 4'd5;
  localparam logic [PC_W-1:0] BASE_DECAPS = 4'd11;

  function automatic logic [INST_W-1:0] xfer(
    input opcode_e     op,
    input logic [11:0] addr,
    input logic [5:0]  len,
    input logic [1:0]  port
  );
    return {op, addr, len, port, 5'b0};
  endfunction

  function automatic logic [INST_W-1:0] comp(
    input opcode_e    op,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [3:0] c,
    input logic [1:0] m
  );
    return {op, a, b, c, m, 11'b0};
  endfunction

  function automatic logic [CNT_W-1:0] mm_lat(
    input logic [1:0] lvl
  );
    logic [CNT_W-1:0] r;
    r = LAT_MM_640;
    unique case (1'b1)
      lvl == 2'b01: r = LAT_MM_976;
      lvl == 2'b10: r = LAT_MM_1344;
      default:      r = LAT_MM_640;
    endcase
    return r;
  endfunction

  function automatic logic [PC_W-1:0] prog_base(
    input logic [1:0] md
  );
    logic [PC_W-1:0] r;
    r = BASE_KEYGEN;
    unique case (1'b1)
      md == 2'b01: r = BASE_ENCAPS;
      md == 2'b10: r = BASE_DECAPS;
      default:     r = BASE_KEYGEN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/frodo_if.sv
// FrodoKEM sequencer control/status bundle.
// master launches operations, slave is the sequencer.
interface frodo_if #(
  parameter int INST_WIDTH = 28
);
  logic [1:0]            level;
  logic [1:0]            mode_ctrl;
  logic                  start;
  logic [INST_WIDTH-1:0] inst;
  logic                  inst_valid;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output level, mode_ctrl, start,
    input  inst, inst_valid, busy, done, error
  );

  modport slave (
    input  level, mode_ctrl, start,
    output inst, inst_valid, busy, done, error
  );
endinterface

// File: rtl/frodo_prog_rom.sv
// Microprogram ROM: keygen, encaps, decaps back to back.
// Unused slots read as END so a stray pc always terminates.
module frodo_prog_rom
  import frodo_pkg::*;
#(
  parameter int INST_WIDTH = 28
) (
  input  logic [PC_W-1:0]       pc,
  output logic [INST_WIDTH-1:0] word
);

  logic [INST_W-1:0] w;

  // Fixed program contents indexed by pc.
  always_comb begin
    w = {OP_END, 25'b0};
    case (pc)
      BASE_KEYGEN + 4'd0: w = xfer(OP_LOAD, 12'd0, 6'd4, 2'd0);
      BASE_KEYGEN + 4'd1: w = {OP_SAMPLE, 25'b0};
      BASE_KEYGEN + 4'd2: w = comp(OP_MATMUL, 4'd0, 4'd1, 4'd2, 2'd0);
      BASE_KEYGEN + 4'd3: w = xfer(OP_STORE, 12'd100, 6'd4, 2'd1);
      BASE_KEYGEN + 4'd4: w = {OP_END, 25'b0};
      BASE_ENCAPS + 4'd0: w = xfer(OP_LOAD, 12'd100, 6'd4, 2'd0);
      BASE_ENCAPS + 4'd1: w = {OP_SAMPLE, 25'b0};
      BASE_ENCAPS + 4'd2: w = comp(OP_MATMUL_T, 4'd0, 4'd3, 4'd1, 2'd0);
      BASE_ENCAPS + 4'd3: w = comp(OP_CODEC, 4'd0, 4'd0, 4'd2, 2'd0);
      BASE_ENCAPS + 4'd4: w = xfer(OP_STORE, 12'd200, 6'd2, 2'd1);
      BASE_ENCAPS + 4'd5: w = {OP_END, 25'b0};
      BASE_DECAPS + 4'd0: w = xfer(OP_LOAD, 12'd200, 6'd2, 2'd0);
      BASE_DECAPS + 4'd1: w = comp(OP_MATMUL, 4'd1, 4'd2, 4'd3, 2'd0);
      BASE_DECAPS + 4'd2: w = comp(OP_CODEC, 4'd0, 4'd0, 4'd3, 2'd1);
      BASE_DECAPS + 4'd3: w = xfer(OP_STORE, 12'd300, 6'd4, 2'd1);
      BASE_DECAPS + 4'd4: w = {OP_END, 25'b0};
      default:            w = {OP_END, 25'b0};
    endcase
  end

  assign word = INST_WIDTH'(w);

endmodule

// File: rtl/frodo_top.sv
// FrodoKEM instruction sequencer.
// Issues one ROM instruction per op latency, with watchdog.
module frodo_top
  import frodo_pkg::*;
#(
  parameter int INST_WIDTH = 28,
  parameter int ADDR_WIDTH = 12,
  parameter int TIME       = 100000
) (
  input logic    clk,
  input logic    rstn,
  frodo_if.slave bus
);

  localparam int OP_HI  = INST_WIDTH - 1;
  localparam int LEN_HI = INST_WIDTH - 4 - ADDR_WIDTH;
  localparam int WD_W   = $clog2(TIME + 1);
  // wd counts busy cycles from 1; the done pulse
  // then lands on busy cycle TIME.
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIME - 2);

  state_e                state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [1:0]            lvl_q, lvl_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  vld_q, vld_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [INST_WIDTH-1:0] rom_word;
  opcode_e               op;
  logic [LEN_W-1:0]      len;
  logic [CNT_W-1:0]      lat;
  logic                  timeout;

  frodo_prog_rom #(
    .INST_WIDTH(INST_WIDTH)
  ) u_rom (
    .pc  (pc_q),
    .word(rom_word)
  );

  assign op  = opcode_e'(rom_word[OP_HI -: 3]);
  assign len = rom_word[LEN_HI -: LEN_W];

  // Execution latency of the instruction at pc.
  always_comb begin
    lat = '0;
    unique case (op)
      OP_LOAD, OP_STORE:
        lat = (len == '0) ? LAT_XFER_0
                          : {2'b0, len} + 8'd1;
      OP_SAMPLE:             lat = LAT_SAMPLE;
      OP_MATMUL, OP_MATMUL_T: lat = mm_lat(lvl_q);
      OP_CODEC:              lat = LAT_CODEC;
      default:               lat = '0;
    endcase
  end

  // Sequencer next state and registered output values.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    lvl_d   = lvl_q;
    inst_d  = inst_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    timeout = (wd_q == WD_LIM);
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !done_q) begin
          lvl_d = bus.level;
          err_d = 1'b0;
          wd_d  = WD_W'(1);
          cnt_d = '0;
          if (bus.level == 2'b11 ||
              bus.mode_ctrl == 2'b11) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            pc_d    = prog_base(bus.mode_ctrl);
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        wd_d = wd_q + WD_W'(1);
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          inst_d = rom_word;
          vld_d  = 1'b1;
          if (op == OP_END) begin
            state_d = S_FINISH;
          end else if (op == OP_RSVD) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            cnt_d   = lat;
            pc_d    = pc_q + PC_W'(1);
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        wd_d = wd_q + WD_W'(1);
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else if (cnt_q == 8'd1) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // busy spans launch through the done pulse
    busy_d = (state_d != S_IDLE) ||
             (state_q != S_IDLE);
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      lvl_q   <= '0;
      inst_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      lvl_q   <= lvl_d;
      inst_q  <= inst_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.inst       = inst_q;
  assign bus.inst_valid = vld_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = err_q;

endmodule

// File: tb/tb_frodo_top.sv
// Directed bench for the FrodoKEM sequencer.
// Expected words and gaps are hand-encoded constants.
module tb_frodo_top;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  frodo_if #(.INST_WIDTH(28)) b1();
  frodo_if #(.INST_WIDTH(28)) b2();

  frodo_top #(
    .INST_WIDTH(28),
    .ADDR_WIDTH(12),
    .TIME      (100000)
  ) dut1 (
    .clk (clk),
    .rstn(rstn),
    .bus (b1)
  );

  frodo_top #(
    .INST_WIDTH(28),
    .ADDR_WIDTH(12),
    .TIME      (50)
  ) dut2 (
    .clk (clk),
    .rstn(rstn),
    .bus (b2)
  );

  int n_run  = 0;
  int n_fail = 0;

  logic [27:0] enc_i [6] = '{28'h00C8200, 28'h6000000,
    28'hA062000, 28'hC004000, 28'h2190120, 28'hE000000};
  int          enc_g [6] = '{1, 6, 25, 123, 17, 4};
  logic [27:0] kg_i [5] = '{28'h0000200, 28'h6000000,
    28'h8024000, 28'h20C8220, 28'hE000000};
  int          kg_g [5] = '{1, 6, 25, 169, 6};
  logic [27:0] dc_i [5] = '{28'h0190100, 28'h8246000,
    28'hC006800, 28'h2258220, 28'hE000000};
  int          dc_g [5] = '{1, 4, 81, 17, 6};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_v(input int bound, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!b1.inst_valid && cyc < bound);
  endtask

  task automatic launch1(input logic [1:0] lv,
                         input logic [1:0] md);
    b1.level     = lv;
    b1.mode_ctrl = md;
    b1.start     = 1'b1;
    tick();
    b1.start     = 1'b0;
  endtask

  initial begin
    int cyc;
    int tot;
    int nv;
    rstn         = 1'b0;
    b1.start     = 1'b0;
    b1.level     = 2'b00;
    b1.mode_ctrl = 2'b00;
    b2.start     = 1'b0;
    b2.level     = 2'b00;
    b2.mode_ctrl = 2'b00;
    repeat (5) tick();
    chk("rst_inst", 32'(b1.inst), 0);
    chk("rst_valid", 32'(b1.inst_valid), 0);
    chk("rst_busy", 32'(b1.busy), 0);
    chk("rst_done", 32'(b1.done), 0);
    chk("rst_error", 32'(b1.error), 0);
    rstn = 1'b1;
    tick();

    // encaps, Frodo-976; inputs scrambled after launch
    launch1(2'b01, 2'b01);
    chk("enc_busy", 32'(b1.busy), 1);
    b1.level     = 2'b11;
    b1.mode_ctrl = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_v(300, cyc);
      chk($sformatf("enc_gap%0d", i), cyc, enc_g[i]);
      chk($sformatf("enc_inst%0d", i),
          32'(b1.inst), 32'(enc_i[i]));
    end
    tick();
    chk("enc_done", 32'(b1.done), 1);
    chk("enc_busy_done", 32'(b1.busy), 1);
    chk("enc_err", 32'(b1.error), 0);
    // start coincident with done is dropped
    launch1(2'b00, 2'b00);
    chk("enc_done_clr", 32'(b1.done), 0);
    chk("enc_busy_clr", 32'(b1.busy), 0);
    tick();
    chk("coinc_ignored", 32'(b1.busy), 0);

    // keygen, Frodo-1344, with a stray start mid-run
    launch1(2'b10, 2'b00);
    tot = 0;
    for (int i = 0; i < 5; i++) begin
      int extra;
      extra = 0;
      if (i == 2) begin
        b1.mode_ctrl = 2'b10;
        b1.start     = 1'b1;
        tick();
        b1.start     = 1'b0;
        extra        = 1;
      end
      wait_v(300, cyc);
      cyc = cyc + extra;
      tot = tot + cyc;
      chk($sformatf("kg_gap%0d", i), cyc, kg_g[i]);
      chk($sformatf("kg_inst%0d", i),
          32'(b1.inst), 32'(kg_i[i]));
    end
    tick();
    tot++;
    chk("kg_done", 32'(b1.done), 1);
    chk("kg_total", tot, 208);
    tick();
    chk("kg_idle", 32'(b1.busy), 0);

    // illegal level
    launch1(2'b11, 2'b00);
    chk("ill_lv_err", 32'(b1.error), 1);
    chk("ill_lv_busy", 32'(b1.busy), 1);
    tick();
    chk("ill_lv_done", 32'(b1.done), 1);
    chk("ill_lv_valid", 32'(b1.inst_valid), 0);
    tick();
    chk("ill_lv_sticky", 32'(b1.error), 1);
    chk("ill_lv_idle", 32'(b1.busy), 0);

    // illegal mode
    launch1(2'b00, 2'b11);
    chk("ill_md_valid", 32'(b1.inst_valid), 0);
    tick();
    chk("ill_md_done", 32'(b1.done), 1);
    chk("ill_md_err", 32'(b1.error), 1);
    tick();

    // decaps, reset during EXEC, then full rerun
    launch1(2'b00, 2'b10);
    chk("dc_err_clr", 32'(b1.error), 0);
    wait_v(300, cyc);
    chk("dc_first_gap", cyc, 1);
    chk("dc_first", 32'(b1.inst), 32'(dc_i[0]));
    tick();
    tick();
    rstn = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(b1.busy), 0);
    chk("mid_rst_inst", 32'(b1.inst), 0);
    chk("mid_rst_done", 32'(b1.done), 0);
    rstn = 1'b1;
    launch1(2'b00, 2'b10);
    for (int i = 0; i < 5; i++) begin
      wait_v(300, cyc);
      chk($sformatf("dc_gap%0d", i), cyc, dc_g[i]);
      chk($sformatf("dc_inst%0d", i),
          32'(b1.inst), 32'(dc_i[i]));
    end
    tick();
    chk("dc_done", 32'(b1.done), 1);
    chk("dc_ok", 32'(b1.error), 0);

    // watchdog, TIME=50, decaps at Frodo-640
    b2.level     = 2'b00;
    b2.mode_ctrl = 2'b10;
    b2.start     = 1'b1;
    tick();
    b2.start     = 1'b0;
    cyc = 0;
    nv  = 0;
    while (!b2.done && cyc < 300) begin
      tick();
      cyc++;
      if (b2.inst_valid) nv++;
    end
    chk("wd_done_at", cyc, 49);
    chk("wd_err", 32'(b2.error), 1);
    chk("wd_issued", nv, 2);
    tick();
    chk("wd_idle", 32'(b2.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
